// File: rtl/fetch_decode_mem.sv
// Instruction store, LEGv8 decode, data store and writeback mux for the single-cycle datapath.
// Optional macro ALIGN_CHECK_EN: word-alignment check on data-store accesses.
module fetch_decode_mem #(
  parameter int IMEM_WORDS = 64,
  parameter int DMEM_WORDS = 64
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] readAddress,
  input  logic        imem_we,
  input  logic [31:0] imem_waddr,
  input  logic [31:0] imem_wdata,
  output logic [31:0] instruction,
  output logic        unconditionalBranchFlag,
  output logic        branchFlag,
  output logic        memReadFlag,
  output logic        memToRegFlag,
  output logic        memWriteFlag,
  output logic [1:0]  aluOp,
  output logic        aluSRC,
  output logic        regWrite,
  output logic [4:0]  readRegister1,
  output logic [4:0]  readRegister2,
  output logic [4:0]  writeRegister,
  input  logic [31:0] aluResult,
  input  logic [31:0] writeData,
  output logic [31:0] readData,
  output logic        misaligned
);
  localparam int IAW = $clog2(IMEM_WORDS);
  localparam int DAW = $clog2(DMEM_WORDS);

  logic [31:0] imem_q [IMEM_WORDS];
  logic [31:0] dmem_q [DMEM_WORDS];

  logic           fetch_ok, prog_ok, data_ok, align_ok, dmem_we;
  logic [IAW-1:0] fetch_idx, prog_idx;
  logic [DAW-1:0] data_idx;
  logic [31:0]    mem_rd;
  logic [10:0]    op11;
  logic           is_rtype;
  logic           unused_bits;

  // Byte offsets within a word carry no meaning for either store.
  assign unused_bits = ^{readAddress[1:0], imem_waddr[1:0], aluResult[1:0]};

  assign fetch_ok  = (readAddress[31:IAW+2] == '0);
  assign fetch_idx = readAddress[IAW+1:2];
  assign prog_ok   = (imem_waddr[31:IAW+2] == '0);
  assign prog_idx  = imem_waddr[IAW+1:2];

  assign instruction = fetch_ok ? imem_q[fetch_idx] : 32'h0;

  // Program image survives reset; programming is only held off while in reset.
  always_ff @(posedge clock) begin
    if (reset_n && imem_we && prog_ok)
      imem_q[prog_idx] <= imem_wdata;
  end

  assign op11     = instruction[31:21];
  assign is_rtype = (op11 == 11'h458) || (op11 == 11'h658) || (op11 == 11'h450) ||
                    (op11 == 11'h550) || (op11 == 11'h650);

  always_comb begin
    unconditionalBranchFlag = 1'b0;
    branchFlag              = 1'b0;
    memReadFlag             = 1'b0;
    memToRegFlag            = 1'b0;
    memWriteFlag            = 1'b0;
    aluOp                   = 2'b00;
    aluSRC                  = 1'b0;
    regWrite                = 1'b0;
    readRegister1           = instruction[9:5];
    writeRegister           = instruction[4:0];
    readRegister2           = is_rtype ? instruction[20:16] : instruction[4:0];
    if (is_rtype) begin
      regWrite = 1'b1;
      aluOp    = 2'b10;
    end else if (op11 == 11'h7C2) begin
      aluSRC       = 1'b1;
      memReadFlag  = 1'b1;
      memToRegFlag = 1'b1;
      regWrite     = 1'b1;
    end else if (op11 == 11'h7C0) begin
      aluSRC       = 1'b1;
      memWriteFlag = 1'b1;
    end else if (instruction[31:24] == 8'hB4) begin
      branchFlag = 1'b1;
      aluOp      = 2'b01;
    end else if (instruction[31:26] == 6'h05) begin
      unconditionalBranchFlag = 1'b1;
    end
  end

`ifdef ALIGN_CHECK_EN
  assign align_ok   = (aluResult[1:0] == 2'b00);
  assign misaligned = (memReadFlag | memWriteFlag) & ~align_ok;
`else
  assign align_ok   = 1'b1;
  assign misaligned = 1'b0;
`endif

  assign data_ok  = (aluResult[31:DAW+2] == '0) && align_ok;
  assign data_idx = aluResult[DAW+1:2];
  assign dmem_we  = memWriteFlag && data_ok;

  assign mem_rd   = (memReadFlag && data_ok) ? dmem_q[data_idx] : 32'h0;
  assign readData = memToRegFlag ? mem_rd : aluResult;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DMEM_WORDS; i++)
        dmem_q[i] <= 32'h0;
    end else if (dmem_we) begin
      dmem_q[data_idx] <= writeData;
    end
  end

endmodule

// File: tb/tb_fetch_decode_mem.sv
// Directed plus randomized checks of fetch_decode_mem against a behavioural model.
module tb_fetch_decode_mem;
  logic        clock = 1'b0;
  logic        reset_n;
  logic [31:0] readAddress, imem_waddr, imem_wdata, aluResult, writeData;
  logic        imem_we;
  logic [31:0] instruction, readData;
  logic        unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag, memWriteFlag;
  logic [1:0]  aluOp;
  logic        aluSRC, regWrite, misaligned;
  logic [4:0]  readRegister1, readRegister2, writeRegister;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] imem_m [64];
  logic [31:0] dmem_m [64];

  fetch_decode_mem dut (
    .clock(clock), .reset_n(reset_n), .readAddress(readAddress),
    .imem_we(imem_we), .imem_waddr(imem_waddr), .imem_wdata(imem_wdata),
    .instruction(instruction), .unconditionalBranchFlag(unconditionalBranchFlag),
    .branchFlag(branchFlag), .memReadFlag(memReadFlag), .memToRegFlag(memToRegFlag),
    .memWriteFlag(memWriteFlag), .aluOp(aluOp), .aluSRC(aluSRC), .regWrite(regWrite),
    .readRegister1(readRegister1), .readRegister2(readRegister2), .writeRegister(writeRegister),
    .aluResult(aluResult), .writeData(writeData), .readData(readData), .misaligned(misaligned)
  );

  initial forever #5 clock = ~clock;

  // {ub, br, mr, m2r, mw, aluOp, src, rw, rr1, rr2, wr}
  function automatic logic [23:0] ctrl(input logic ub, br, mr, m2r, mw, input logic [1:0] op,
                                       input logic src, rw, input logic [4:0] r1, r2, w);
    return {ub, br, mr, m2r, mw, op, src, rw, r1, r2, w};
  endfunction

  function automatic logic [23:0] obs_ctrl();
    return {unconditionalBranchFlag, branchFlag, memReadFlag, memToRegFlag, memWriteFlag,
            aluOp, aluSRC, regWrite, readRegister1, readRegister2, writeRegister};
  endfunction

  // Instruction-class table: which class a word falls into decides every flag.
  function automatic logic [23:0] model_decode(input logic [31:0] w);
    int op = int'(w >> 21);
    bit r = (op == 'h458) || (op == 'h658) || (op == 'h450) || (op == 'h550) || (op == 'h650);
    logic [4:0] r1 = w[9:5];
    logic [4:0] wr = w[4:0];
    logic [4:0] r2 = r ? w[20:16] : w[4:0];
    if (r)                        return ctrl(0,0,0,0,0,2'b10,0,1,r1,r2,wr);
    if (op == 'h7C2)              return ctrl(0,0,1,1,0,2'b00,1,1,r1,r2,wr);
    if (op == 'h7C0)              return ctrl(0,0,0,0,1,2'b00,1,0,r1,r2,wr);
    if ((w >> 24) == 32'hB4)      return ctrl(0,1,0,0,0,2'b01,0,0,r1,r2,wr);
    if ((w >> 26) == 32'h05)      return ctrl(1,0,0,0,0,2'b00,0,0,r1,r2,wr);
    return ctrl(0,0,0,0,0,2'b00,0,0,r1,r2,wr);
  endfunction

  function automatic bit model_aligned(input logic [31:0] a);
`ifdef ALIGN_CHECK_EN
    return (a % 4) == 0;
`else
    return 1'b1;
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic prog(input logic [31:0] a, input logic [31:0] d);
    imem_we = 1'b1; imem_waddr = a; imem_wdata = d;
    step();
    imem_we = 1'b0;
  endtask

  logic [31:0] instr, alu, wd, exp_i, memval, ra;
  logic [23:0] dv;
  bit          inr, aok;
  int          k, sel;

  initial begin
    reset_n = 1'b0; readAddress = 32'h1000; imem_we = 1'b0; imem_waddr = 0; imem_wdata = 0;
    aluResult = 0; writeData = 0;
    for (int i = 0; i < 64; i++) dmem_m[i] = 32'h0;
    step(); step();
    reset_n = 1'b1;

    prog(32'd0,  32'hF8400041);
    prog(32'd4,  32'h8B020023);
    prog(32'd8,  32'h00000000);
    prog(32'd12, 32'hF8000045);
    prog(32'd16, 32'hB4000040);
    prog(32'd20, 32'h14000003);
    prog(32'd40, 32'h12345678);
    prog(32'd256, 32'hFFFFFFFF);

    // Programming is ignored during reset; word 10 must keep its value.
    reset_n = 1'b0;
    prog(32'd40, 32'hAAAA5555);
    reset_n = 1'b1;
    readAddress = 32'd40; #1;
    chk("imem_we_in_reset", instruction, 32'h12345678);

    readAddress = 32'd0; aluResult = 32'd8; #1;
    chk("ldur_instr", instruction, 32'hF8400041);
    chk("ldur_ctrl", {8'h0, obs_ctrl()}, {8'h0, ctrl(0,0,1,1,0,2'b00,1,1,5'd2,5'd1,5'd1)});
    chk("read_after_reset", readData, 32'h0);

    readAddress = 32'd4; aluResult = 32'd1234; #1;
    chk("add_ctrl", {8'h0, obs_ctrl()}, {8'h0, ctrl(0,0,0,0,0,2'b10,0,1,5'd1,5'd2,5'd3)});
    chk("wb_alu", readData, 32'd1234);

    readAddress = 32'd8; #1;
    chk("zero_flags", {8'h0, obs_ctrl()}, {8'h0, ctrl(0,0,0,0,0,2'b00,0,0,5'd0,5'd0,5'd0)});

    // Store DEADBEEF to address 8; the load before the edge still sees the old value.
    readAddress = 32'd0; aluResult = 32'd8; writeData = 32'hDEADBEEF; #1;
    chk("read_before_write", readData, 32'h0);
    readAddress = 32'd12; #1;
    chk("stur_flags", {31'h0, memWriteFlag}, 32'h1);
    chk("stur_wb", readData, 32'd8);
    step();
    dmem_m[2] = 32'hDEADBEEF;
    readAddress = 32'd0; #1;
    chk("read_after_write", readData, 32'hDEADBEEF);

    readAddress = 32'd16; #1;
    chk("cbz_ctrl", {8'h0, obs_ctrl()}, {8'h0, ctrl(0,1,0,0,0,2'b01,0,0,5'd2,5'd0,5'd0)});
    readAddress = 32'd20; #1;
    chk("b_ctrl", {8'h0, obs_ctrl()}, {8'h0, ctrl(1,0,0,0,0,2'b00,0,0,5'd0,5'd3,5'd3)});

    readAddress = 32'd256; #1;
    chk("fetch_oor", instruction, 32'h0);

    // Asynchronous reset in mid-cycle clears the data store immediately.
    readAddress = 32'd0; aluResult = 32'd8; #2;
    reset_n = 1'b0; #1;
    chk("async_clear", readData, 32'h0);
    for (int i = 0; i < 64; i++) dmem_m[i] = 32'h0;
    readAddress = 32'd12; writeData = 32'h11111111;
    step();
    reset_n = 1'b1;
    readAddress = 32'd0; #1;
    chk("write_blocked_in_reset", readData, 32'h0);

    // Misaligned store to byte 6.
    readAddress = 32'd12; aluResult = 32'd6; writeData = 32'hCAFEF00D; #1;
`ifdef ALIGN_CHECK_EN
    chk("misaligned_flag", {31'h0, misaligned}, 32'h1);
`else
    chk("misaligned_flag", {31'h0, misaligned}, 32'h0);
    dmem_m[1] = 32'hCAFEF00D;
`endif
    step();
    readAddress = 32'd0; aluResult = 32'd4; #1;
    chk("misaligned_mem", readData, dmem_m[1]);

    // Out-of-range store must not alias onto word 0.
    readAddress = 32'd12; aluResult = 32'd256; writeData = 32'h55AA55AA;
    step();
    readAddress = 32'd0; #1;
    chk("ldur_oor", readData, 32'h0);
    aluResult = 32'd0; #1;
    chk("dmem_no_alias", readData, dmem_m[0]);
    readAddress = 32'h1000;

    for (int i = 0; i < 64; i++) imem_m[i] = 32'h0;
    for (int i = 0; i < 64; i++) prog(i * 4, 32'h0);

    for (int it = 0; it < 400; it++) begin
      sel = $urandom_range(0, 5);
      case (sel)
        0: begin
          k = $urandom_range(0, 4);
          instr = {11'h0, $urandom_range(0, 21'h1FFFFF)};
          instr[31:21] = (k == 0) ? 11'h458 : (k == 1) ? 11'h658 : (k == 2) ? 11'h450 :
                         (k == 3) ? 11'h550 : 11'h650;
        end
        1: begin instr = $urandom; instr[31:21] = 11'h7C2; end
        2: begin instr = $urandom; instr[31:21] = 11'h7C0; end
        3: begin instr = $urandom; instr[31:24] = 8'hB4; end
        4: begin instr = $urandom; instr[31:26] = 6'h05; end
        default: instr = $urandom;
      endcase
      k = $urandom_range(0, 63);
      prog(k * 4, instr);
      imem_m[k] = instr;

      ra = ($urandom_range(0, 9) == 0) ? 32'd256 + ($urandom_range(0, 63) * 4) : k * 4;
      if ($urandom_range(0, 9) == 0) alu = $urandom;
      else alu = ($urandom_range(0, 15) * 4) + (($urandom_range(0, 3) == 0) ? $urandom_range(0, 3) : 0);
      wd = $urandom;
      readAddress = ra; aluResult = alu; writeData = wd; #1;

      exp_i  = (ra < 256) ? imem_m[ra / 4] : 32'h0;
      dv     = model_decode(exp_i);
      inr    = alu < 256;
      aok    = model_aligned(alu);
      memval = (dv[21] && inr && aok) ? dmem_m[alu / 4] : 32'h0;
      chk("rnd_instr", instruction, exp_i);
      chk("rnd_ctrl", {8'h0, obs_ctrl()}, {8'h0, dv});
      chk("rnd_readData", readData, dv[20] ? memval : alu);
      chk("rnd_misaligned", {31'h0, misaligned}, {31'h0, (dv[21] | dv[19]) & ~aok});
      step();
      if (dv[19] && inr && aok) dmem_m[alu / 4] = wd;
      readAddress = 32'h1000;
    end

    // Final sweep of the data store through loads.
    prog(32'd0, 32'hF8400041);
    readAddress = 32'd0;
    for (int i = 0; i < 64; i++) begin
      aluResult = i * 4; #1;
      chk("final_dmem", readData, dmem_m[i]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/fetch_decode_mem.md
# fetch_decode_mem

Combined instruction-fetch, decode and data-memory block for the single-cycle LEGv8-style datapath. It holds the 64-word instruction store, decodes the fetched word into datapath control flags and register indices, and provides the 64-word data store. Writeback selection between memory data and ALU result is also done here. It sits between the PC, the register-file/operand-prep stage and the ALU.

## Interface
Parameters:
- IMEM_WORDS, 64, instruction store depth (32-bit words, power of 2)
- DMEM_WORDS, 64, data store depth (32-bit words, power of 2)

Ports:
- clock  in  1  single clock; all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- readAddress  in  32  byte address of instruction fetch (from PC)
- imem_we  in  1  instruction-store program strobe
- imem_waddr  in  32  byte address for programming
- imem_wdata  in  32  instruction word to program
- instruction  out  32  fetched instruction
- unconditionalBranchFlag  out  1  B decoded
- branchFlag  out  1  CBZ decoded
- memReadFlag  out  1  load decoded
- memToRegFlag  out  1  writeback selects memory data
- memWriteFlag  out  1  store decoded
- aluOp  out  2  00 add (address), 01 pass/zero-test, 10 R-type function
- aluSRC  out  1  ALU operand B is sign-extended immediate
- regWrite  out  1  register file write enable
- readRegister1 / readRegister2 / writeRegister  out  5 each  register indices
- aluResult  in  32  ALU result (data address / writeback value)
- writeData  in  32  store data (register readData2)
- readData  out  32  writeback value
- misaligned  out  1  alignment fault (see Configuration)

## Operation
- Fetch: word index = readAddress[log2(IMEM_WORDS)+1:2]; address ≥ 4·IMEM_WORDS returns 32'h0. imem_we writes imem_wdata at the same indexing on the clock edge; out-of-range writes are dropped.
- Decode (combinational, on `instruction`): readRegister1 = [9:5]; writeRegister = [4:0]; readRegister2 = [20:16] for R-type, [4:0] otherwise.
  - R-type [31:21] = 458 ADD, 658 SUB, 450 AND, 550 ORR, 650 EOR (hex): regWrite=1, aluOp=10; all other flags 0.
  - LDUR [31:21]=7C2: aluSRC, memReadFlag, memToRegFlag, regWrite=1; aluOp=00.
  - STUR [31:21]=7C0: aluSRC, memWriteFlag=1; aluOp=00.
  - CBZ [31:24]=B4: branchFlag=1; aluOp=01.
  - B [31:26]=05: unconditionalBranchFlag=1.
  - Any other encoding, including 0: all flags 0, aluOp=00.
- Data store: word index = aluResult[log2(DMEM_WORDS)+1:2]. Write of writeData on the rising edge when memWriteFlag=1. The memory read value is the addressed word when memReadFlag=1, else 0. Out-of-range addresses read 0 and ignore writes.
- Writeback: readData = memToRegFlag ? memory read value : aluResult.

## Timing
- Fetch, decode, memory read and writeback mux are combinational with zero-cycle latency.
- The data write takes effect at the rising edge. A same-cycle read of the same address returns the pre-write value, and the new value is visible after the edge.
- memReadFlag and memWriteFlag together: the read returns old data and the write commits at the edge.
- Reset (async assert, any time): all data-store words clear to 0 immediately, and writes are blocked while reset_n=0.
- The instruction store is not cleared by reset. imem_we is ignored while reset_n=0.
- Control outputs have no reset state: they always reflect the decode of the current `instruction`.

## Configuration
- ALIGN_CHECK_EN defined:
  - misaligned=1 when (memReadFlag|memWriteFlag) and aluResult[1:0]≠0.
  - The write is suppressed and the memory read value is forced to 0 for that access.
- ALIGN_CHECK_EN undefined:
  - misaligned tied to 0.
  - aluResult[1:0] ignored.

## Test plan
- Program word 0 = F8400000|... as LDUR X1,[X2,#0] (32'hF8400041); readAddress=0 -> instruction=F8400041, memReadFlag=memToRegFlag=regWrite=aluSRC=1, aluOp=00, rr1=2, wr=1.
- ADD X3,X1,X2 (32'h8B020023) -> regWrite=1, aluOp=10, rr1=1, rr2=2, wr=3, others 0; instruction 0 -> all flags 0.
- STUR X5 (memWriteFlag=1), aluResult=8, writeData=DEADBEEF, one edge; then LDUR aluResult=8 -> readData=DEADBEEF. Same-cycle read during write -> old value 0.
- CBZ (32'hB4000040) -> branchFlag=1, aluOp=01, rr2=0. B (32'h14000003) -> unconditionalBranchFlag=1 only.
- Assert reset_n=0 mid-cycle after the store -> read of address 8 returns 0 immediately. memToRegFlag=0 with aluResult=1234 -> readData=1234.
- ALIGN_CHECK_EN: STUR at aluResult=6 -> misaligned=1, memory unchanged. Without the macro, the same store writes word index 1 and misaligned=0.
